// File: rtl/spi_frame_master.sv
// spi_frame_master
// Serialises one write frame [CMD | DATA bytes] onto an SPI mode-0 bus, then
// emits trailing sclk pulses with cs_n high so the slave can commit its output
// register. Every output is driven straight from a flop.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           frame request, taken only while ready=1
//   cmd [7:0]       command byte, sent first
//   data[8*N-1:0]   payload, byte 0 (data[7:0]) sent first, LSB first per byte
//   ready           high only in IDLE
//   busy            high from acceptance through the done cycle
//   done            one-cycle pulse at the end of the frame
//   sclk/mosi/cs_n  SPI bus (sclk idles low, mosi idles low, cs_n idles high)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | bus quiet, ready=1, waiting for start
// SHIFT  | cs_n low, one bit per sclk period (low phase, then high phase)
// POST   | cs_n high, POST_CLKS commit pulses on sclk with mosi low
// DONE   | single cycle with done=1 before returning to IDLE

module spi_frame_master #(
    parameter int N_BYTES   = 2,
    parameter int CLK_DIV   = 1,
    parameter int POST_CLKS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           cmd,
    input  logic [N_BYTES*8-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs_n
);

    localparam int FRAME_BITS = 8 * (N_BYTES + 1);
    // The first bit goes straight to mosi at acceptance, so the shift register
    // only has to hold the bits still to come.
    localparam int REM_W  = FRAME_BITS - 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam int POST_W = (POST_CLKS > 1) ? $clog2(POST_CLKS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [POST_W-1:0] POST_LOAD = POST_W'(POST_CLKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   shreg_q, shreg_d;
    logic [DIV_W-1:0]   div_q,   div_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [POST_W-1:0]  post_q,  post_d;
    logic               sclk_q,  sclk_d;
    logic               mosi_q,  mosi_d;
    logic               cs_n_q,  cs_n_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            post_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            post_q  <= post_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        post_d  = post_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && ready_q) begin
                    shreg_d = {data, cmd[7:1]};
                    mosi_d  = cmd[0];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // End of a high phase: the falling edge is the only
                        // point where mosi is allowed to move.
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                            post_d  = POST_LOAD;
                            state_d = ST_POST;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            mosi_d  = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[REM_W-1:1]};
                        end
                    end
                end
            end

            ST_POST: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (post_q == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            post_d = post_q - 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Testbench for spi_frame_master: two instances (CLK_DIV=1 and CLK_DIV=3)
// observed by a bus monitor that captures the frame on sclk rising edges,
// measures sclk phase lengths and models the spc slave's output register.

module tb_spi_frame_master;

    localparam int N_BYTES    = 2;
    localparam int POST_CLKS  = 2;
    localparam int FRAME_BITS = 8 * (N_BYTES + 1);

    logic        clk;
    logic        rst_n;
    logic        start_i  [2];
    logic [7:0]  cmd_i    [2];
    logic [15:0] data_i   [2];
    logic        ready_o  [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic        sclk_o   [2];
    logic        mosi_o   [2];
    logic        cs_n_o   [2];

    int checks = 0;
    int errors = 0;

    // monitor state, per instance
    logic        prev_sclk [2];
    logic        prev_mosi [2];
    logic        prev_csn  [2];
    logic [31:0] fbits     [2];
    int          nbits     [2];
    int          post_n    [2];
    int          run_len   [2];
    bit          armed     [2];
    int          viol      [2];
    int          done_cnt  [2];
    int          fr_cnt    [2];
    logic [15:0] spc_out   [2];
    logic [15:0] exp_spc   [2];

    spi_frame_master #(.N_BYTES(N_BYTES), .CLK_DIV(1), .POST_CLKS(POST_CLKS)) u_div1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .cmd(cmd_i[0]), .data(data_i[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .sclk(sclk_o[0]), .mosi(mosi_o[0]), .cs_n(cs_n_o[0])
    );

    spi_frame_master #(.N_BYTES(N_BYTES), .CLK_DIV(3), .POST_CLKS(POST_CLKS)) u_div3 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .cmd(cmd_i[1]), .data(data_i[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .sclk(sclk_o[1]), .mosi(mosi_o[1]), .cs_n(cs_n_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Bus monitor, sampled once per clk on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                armed[i] = 1'b0;
            end else if (prev_csn[i] && !cs_n_o[i]) begin
                fr_cnt[i]  = fr_cnt[i] + 1;
                nbits[i]   = 0;
                fbits[i]   = '0;
                post_n[i]  = 0;
                armed[i]   = 1'b1;
                run_len[i] = 1;
            end else begin
                if (sclk_o[i] != prev_sclk[i]) begin
                    if (armed[i] && run_len[i] != div_of(i)) viol[i] = viol[i] + 1;
                    run_len[i] = 1;
                end else begin
                    run_len[i] = run_len[i] + 1;
                end
                if (sclk_o[i] && !prev_sclk[i]) begin
                    if (!cs_n_o[i]) begin
                        if (nbits[i] < 32) fbits[i][nbits[i]] = mosi_o[i];
                        nbits[i] = nbits[i] + 1;
                    end else begin
                        post_n[i] = post_n[i] + 1;
                        if (post_n[i] == 1 && nbits[i] == FRAME_BITS && fbits[i][7:0] == 8'h91)
                            spc_out[i] = fbits[i][23:8];
                    end
                end
                if (mosi_o[i] != prev_mosi[i] && !(prev_sclk[i] && !sclk_o[i]))
                    viol[i] = viol[i] + 1;
                if (!prev_csn[i] && cs_n_o[i] && !(prev_sclk[i] && !sclk_o[i] && nbits[i] == FRAME_BITS))
                    viol[i] = viol[i] + 1;
            end
            if (done_o[i]) done_cnt[i] = done_cnt[i] + 1;
            prev_sclk[i] = sclk_o[i];
            prev_mosi[i] = mosi_o[i];
            prev_csn[i]  = cs_n_o[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        check({tag, ".sclk"},  {31'd0, sclk_o[i]},  32'd0);
        check({tag, ".mosi"},  {31'd0, mosi_o[i]},  32'd0);
        check({tag, ".cs_n"},  {31'd0, cs_n_o[i]},  32'd1);
        check({tag, ".ready"}, {31'd0, ready_o[i]}, 32'd1);
        check({tag, ".busy"},  {31'd0, busy_o[i]},  32'd0);
        check({tag, ".done"},  {31'd0, done_o[i]},  32'd0);
    endtask

    // mode: 0 plain, 1 scramble cmd/data after acceptance, 2 pulse start while busy
    task automatic run_frame(input int i, input logic [7:0] c, input logic [15:0] d, input int mode);
        int n;
        int base_done;
        int base_fr;
        int base_viol;
        int exp_lat;
        exp_lat   = 2 * div_of(i) * (FRAME_BITS + POST_CLKS) + 1;
        base_done = done_cnt[i];
        base_fr   = fr_cnt[i];
        base_viol = viol[i];
        n = 0;
        @(negedge clk);
        while (!ready_o[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", {31'd0, ready_o[i]}, 32'd1);
        start_i[i] = 1'b1;
        cmd_i[i]   = c;
        data_i[i]  = d;
        @(posedge clk);
        @(negedge clk);
        start_i[i] = 1'b0;
        check("t0.cs_n", {31'd0, cs_n_o[i]}, 32'd0);
        check("t0.mosi", {31'd0, mosi_o[i]}, {31'd0, c[0]});
        check("t0.busy", {30'd0, busy_o[i], ready_o[i]}, 32'd2);
        // n counts clk edges after t0 whose result has been sampled
        n = 0;
        while (!done_o[i] && n < 400) begin
            if (mode == 1) begin
                cmd_i[i]  = 8'($urandom);
                data_i[i] = 16'($urandom);
            end
            if (mode == 2) start_i[i] = (n >= 10 && n < 14);
            @(negedge clk);
            n++;
        end
        start_i[i] = 1'b0;
        // done was registered by edge t0+n and is seen high by edge t0+n+1
        check("latency", n + 1, exp_lat);
        check("done.busy", {30'd0, busy_o[i], ready_o[i]}, 32'd2);
        @(negedge clk);
        check("after.done",  {31'd0, done_o[i]},  32'd0);
        check("after.ready", {31'd0, ready_o[i]}, 32'd1);
        check("after.busy",  {31'd0, busy_o[i]},  32'd0);
        repeat (12) @(negedge clk);
        #1;
        if (c == 8'h91) exp_spc[i] = d;
        check("bits_cs_low",  nbits[i], FRAME_BITS);
        check("frame_value",  fbits[i], {8'd0, d, c});
        check("post_pulses",  post_n[i], POST_CLKS);
        check("bus_timing",   viol[i], base_viol);
        check("done_pulses",  done_cnt[i], base_done + 1);
        check("frame_count",  fr_cnt[i], base_fr + 1);
        check("spc_out",      {16'd0, spc_out[i]}, {16'd0, exp_spc[i]});
    endtask

    initial begin
        int n;
        int base_done;
        int base_fr;
        logic [15:0] d;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0; cmd_i[i] = 8'h00; data_i[i] = 16'h0000;
            prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0; prev_csn[i] = 1'b1;
            fbits[i] = '0; nbits[i] = 0; post_n[i] = 0; run_len[i] = 0; armed[i] = 1'b0;
            viol[i] = 0; done_cnt[i] = 0; fr_cnt[i] = 0;
            spc_out[i] = 16'h0000; exp_spc[i] = 16'h0000;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // reset while idle
        #2 rst_n = 1'b0;
        #1 check_idle_outputs(0, "rst_idle");
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 8'h91, 16'hFFFF, 0);
        run_frame(0, 8'h91, 16'h1234, 0);
        run_frame(0, 8'h91, 16'h0000, 0);
        run_frame(0, 8'h91, 16'h5555, 0);
        run_frame(1, 8'h91, 16'($urandom), 0);
        run_frame(1, 8'h91, 16'hA5C3, 0);

        // start pulsed while busy must not create a frame
        run_frame(0, 8'h91, 16'h0F0F, 2);

        // inputs changed mid-frame have no effect
        run_frame(0, 8'h91, 16'($urandom), 1);
        run_frame(1, 8'h91, 16'($urandom), 1);

        // random frames, some with non-write commands the slave ignores
        for (int k = 0; k < 6; k++) begin
            run_frame(k % 2, (k % 3 == 2) ? 8'($urandom) : 8'h91, 16'($urandom), 0);
        end

        // start held high across three frames on the CLK_DIV=3 instance
        d = 16'($urandom);
        base_done = done_cnt[1];
        base_fr   = fr_cnt[1];
        @(negedge clk);
        cmd_i[1] = 8'h91; data_i[1] = d; start_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!done_o[1] && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("held.done_seen", {31'd0, done_o[1]}, 32'd1);
            if (k == 2) start_i[1] = 1'b0;
            @(negedge clk);
            check("held.gap_ready", {30'd0, ready_o[1], cs_n_o[1]}, 32'd3);
            if (k < 2) begin
                @(negedge clk);
                check("held.restart_cs", {31'd0, cs_n_o[1]}, 32'd0);
            end
        end
        repeat (120) @(negedge clk);
        #1;
        exp_spc[1] = d;
        check("held.frames", fr_cnt[1], base_fr + 3);
        check("held.dones",  done_cnt[1], base_done + 3);
        check("held.value",  fbits[1], {8'd0, d, 8'h91});
        check("held.spc",    {16'd0, spc_out[1]}, {16'd0, exp_spc[1]});

        // reset in the middle of a frame
        @(negedge clk);
        cmd_i[0] = 8'h91; data_i[0] = 16'($urandom); start_i[0] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        n = 0;
        while (nbits[0] <= 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst.reached_bit10", {31'd0, (nbits[0] > 10)}, 32'd1);
        base_done = done_cnt[0];
        #3 rst_n = 1'b0;
        #1 check_idle_outputs(0, "rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        check("midrst.no_done", done_cnt[0], base_done);
        check_idle_outputs(0, "rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
